// File: rtl/larpix_rx_packet_sorter.sv
// Receive-side packet sorter for the LArPix PISO UART: unloads each word, checks
// odd parity, classifies the declare field and buffers packets in a FWFT FIFO.
module larpix_rx_packet_sorter #(
   parameter int WIDTH           = 64,
   parameter int FIFO_DEPTH      = 16,
   parameter int CNT_WIDTH       = 16,
   parameter bit DROP_BAD_PARITY = 1'b0
) (
   input  logic                          clk,
   input  logic                          reset_n,
   input  logic [WIDTH-1:0]              rx_data,
   input  logic                          rx_empty,
   input  logic                          uart_parity_error,
   output logic                          uld_rx_data,
   output logic [WIDTH-1:0]              pkt_data,
   output logic [1:0]                    pkt_type,
   output logic                          pkt_parity_ok,
   output logic                          pkt_valid,
   input  logic                          pkt_ready,
   output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
   output logic [CNT_WIDTH-1:0]          good_cnt,
   output logic [CNT_WIDTH-1:0]          parity_err_cnt,
   output logic [CNT_WIDTH-1:0]          invalid_cnt,
   output logic [CNT_WIDTH-1:0]          overflow_cnt,
   input  logic                          clear_counters
);

   localparam int AW = $clog2(FIFO_DEPTH);
   localparam int EW = WIDTH + 3;
   localparam logic [AW:0] FULL_CNT = (AW+1)'(FIFO_DEPTH);

   localparam logic [2:0] S_IDLE    = 3'd0;
   localparam logic [2:0] S_UNLOAD  = 3'd1;
   localparam logic [2:0] S_CAPTURE = 3'd2;
   localparam logic [2:0] S_CHECK   = 3'd3;
   localparam logic [2:0] S_PUSH    = 3'd4;
   localparam logic [2:0] S_WAIT    = 3'd5;

   logic [2:0]       state;
   logic [WIDTH-1:0] w_q;
   logic             uerr_q;
   logic             par_ok_q;

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state       <= S_IDLE;
         uld_rx_data <= 1'b0;
         w_q         <= '0;
         uerr_q      <= 1'b0;
         par_ok_q    <= 1'b0;
      end else begin
         uld_rx_data <= 1'b0;
         case (state)
            S_IDLE: begin
               if (!rx_empty) begin
                  state       <= S_UNLOAD;
                  uld_rx_data <= 1'b1;
               end
            end
            S_UNLOAD:  state <= S_CAPTURE;
            S_CAPTURE: begin
               w_q    <= rx_data;
               uerr_q <= uart_parity_error;
               state  <= S_CHECK;
            end
            S_CHECK: begin
               par_ok_q <= (w_q[WIDTH-1] == ~^w_q[WIDTH-2:0]) & ~uerr_q;
               state    <= S_PUSH;
            end
            S_PUSH: state <= S_WAIT;
            S_WAIT: if (rx_empty) state <= S_IDLE;
            default: state <= S_IDLE;
         endcase
      end
   end

   // Decision rules in priority order: invalid declare, parity, overflow, push.
   logic in_push, inv_ev, par_ev, drop_par, pop, full, ovf_ev, push, good_ev;

   always_comb begin
      in_push  = (state == S_PUSH);
      inv_ev   = in_push & (w_q[1:0] == 2'b00);
      par_ev   = in_push & ~inv_ev & ~par_ok_q;
      drop_par = par_ev & DROP_BAD_PARITY;
      pop      = pkt_valid & pkt_ready;
      full     = (fifo_count == FULL_CNT);
      ovf_ev   = in_push & ~inv_ev & ~drop_par & full & ~pop;
      push     = in_push & ~inv_ev & ~drop_par & ~ovf_ev;
      good_ev  = push & par_ok_q;
   end

   logic [EW-1:0] mem [FIFO_DEPTH];
   logic [AW-1:0] wr_ptr, rd_ptr;
   logic [EW-1:0] head;

   always_ff @(posedge clk) begin
      if (reset_n && push) mem[wr_ptr] <= {w_q, w_q[1:0], par_ok_q};
   end

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         wr_ptr     <= '0;
         rd_ptr     <= '0;
         fifo_count <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + 1'b1;
         if (pop)  rd_ptr <= rd_ptr + 1'b1;
         case ({push, pop})
            2'b10:   fifo_count <= fifo_count + 1'b1;
            2'b01:   fifo_count <= fifo_count - 1'b1;
            default: fifo_count <= fifo_count;
         endcase
      end
   end

   // Head outputs read as zero while empty so they are defined after reset.
   always_comb begin
      pkt_valid     = (fifo_count != '0);
      head          = mem[rd_ptr];
      pkt_data      = pkt_valid ? head[EW-1:3] : '0;
      pkt_type      = pkt_valid ? head[2:1]    : 2'b00;
      pkt_parity_ok = pkt_valid ? head[0]      : 1'b0;
   end

   function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] c,
                                                    input logic inc);
      return (inc && (c != '1)) ? c + 1'b1 : c;
   endfunction

   always_ff @(posedge clk) begin
      if (!reset_n || clear_counters) begin
         good_cnt       <= '0;
         parity_err_cnt <= '0;
         invalid_cnt    <= '0;
         overflow_cnt   <= '0;
      end else begin
         good_cnt       <= sat_inc(good_cnt, good_ev);
         parity_err_cnt <= sat_inc(parity_err_cnt, par_ev);
         invalid_cnt    <= sat_inc(invalid_cnt, inv_ev);
         overflow_cnt   <= sat_inc(overflow_cnt, ovf_ev);
      end
   end

endmodule

// File: tb/tb_larpix_rx_packet_sorter.sv
// Directed bench for larpix_rx_packet_sorter: drives a UART-like source and a
// consumer, checking outputs with immediate assertions against hand values.
module tb_larpix_rx_packet_sorter;

   logic        clk = 1'b0;
   logic        reset_n;
   logic [63:0] rx_data;
   logic        rx_empty;
   logic        uart_parity_error;
   logic        uld_rx_data;
   logic [63:0] pkt_data;
   logic [1:0]  pkt_type;
   logic        pkt_parity_ok;
   logic        pkt_valid;
   logic        pkt_ready;
   logic [4:0]  fifo_count;
   logic [15:0] good_cnt, parity_err_cnt, invalid_cnt, overflow_cnt;
   logic        clear_counters;

   int checks   = 0;
   int failures = 0;
   int uld_pulses = 0;
   int base;

   larpix_rx_packet_sorter #(
      .WIDTH(64), .FIFO_DEPTH(16), .CNT_WIDTH(16), .DROP_BAD_PARITY(1'b0)
   ) dut (
      .clk(clk), .reset_n(reset_n), .rx_data(rx_data), .rx_empty(rx_empty),
      .uart_parity_error(uart_parity_error), .uld_rx_data(uld_rx_data),
      .pkt_data(pkt_data), .pkt_type(pkt_type), .pkt_parity_ok(pkt_parity_ok),
      .pkt_valid(pkt_valid), .pkt_ready(pkt_ready), .fifo_count(fifo_count),
      .good_cnt(good_cnt), .parity_err_cnt(parity_err_cnt),
      .invalid_cnt(invalid_cnt), .overflow_cnt(overflow_cnt),
      .clear_counters(clear_counters)
   );

   always #5 clk = ~clk;

   always @(negedge clk) if (uld_rx_data) uld_pulses++;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Odd-parity word carrying index i above a declare field of 2'b01.
   function automatic logic [63:0] make_word(input int i);
      logic [62:0] lo;
      lo = (63'(i) << 8) | 63'd1;
      return {($countones(lo) % 2 == 0), lo};
   endfunction

   task automatic wait_uld();
      bit seen = 0;
      for (int k = 0; k < 20 && !seen; k++) begin
         @(negedge clk);
         if (uld_rx_data) seen = 1;
      end
      check("uld_seen", 64'(seen), 64'd1);
   endtask

   task automatic send_word(input logic [63:0] w, input int hold);
      rx_data  = w;
      rx_empty = 1'b0;
      wait_uld();
      repeat (hold) @(negedge clk);
      rx_empty = 1'b1;
      repeat (4) @(negedge clk);
   endtask

   task automatic pop_one();
      pkt_ready = 1'b1;
      @(negedge clk);
      pkt_ready = 1'b0;
   endtask

   initial begin
      reset_n = 1'b0; rx_data = '0; rx_empty = 1'b1; uart_parity_error = 1'b0;
      pkt_ready = 1'b0; clear_counters = 1'b0;
      repeat (3) @(negedge clk);
      reset_n = 1'b1;
      @(negedge clk);
      check("rst_valid", 64'(pkt_valid), 64'd0);
      check("rst_count", 64'(fifo_count), 64'd0);
      check("rst_uld", 64'(uld_rx_data), 64'd0);
      check("rst_data", pkt_data, 64'd0);
      check("rst_cnts", {good_cnt, parity_err_cnt, invalid_cnt, overflow_cnt}, 64'd0);

      // Good word: 0x5 has two ones, so bit 63 must be set for odd parity.
      send_word(64'h8000_0000_0000_0005, 2);
      check("t1_uld", 64'(uld_pulses), 64'd1);
      check("t1_valid", 64'(pkt_valid), 64'd1);
      check("t1_type", 64'(pkt_type), 64'd1);
      check("t1_parok", 64'(pkt_parity_ok), 64'd1);
      check("t1_data", pkt_data, 64'h8000_0000_0000_0005);
      check("t1_good", 64'(good_cnt), 64'd1);
      pop_one();
      check("t1_empty", 64'(pkt_valid), 64'd0);

      send_word(64'h0000_0000_0000_0005, 2);
      check("t2_valid", 64'(pkt_valid), 64'd1);
      check("t2_parok", 64'(pkt_parity_ok), 64'd0);
      check("t2_perr", 64'(parity_err_cnt), 64'd1);
      check("t2_good", 64'(good_cnt), 64'd1);
      pop_one();

      send_word(64'h0000_0000_0000_0004, 2);
      send_word(64'h1234_0000_0000_0010, 2);
      send_word(64'hFFFF_0000_0000_0000, 2);
      check("t3_inv", 64'(invalid_cnt), 64'd3);
      check("t3_count", 64'(fifo_count), 64'd0);
      check("t3_uld", 64'(uld_pulses), 64'd5);
      check("t3_perr", 64'(parity_err_cnt), 64'd1);

      for (int i = 0; i < 18; i++) send_word(make_word(i), 2);
      check("t4_count", 64'(fifo_count), 64'd16);
      check("t4_ovf", 64'(overflow_cnt), 64'd2);
      check("t4_good", 64'(good_cnt), 64'd17);
      check("t4_uld", 64'(uld_pulses), 64'd23);
      for (int i = 0; i < 16; i++) begin
         check($sformatf("t4_pop%0d", i), pkt_data, make_word(i));
         pop_one();
      end
      check("t4_drained", 64'(fifo_count), 64'd0);

      base = uld_pulses;
      send_word(make_word(100), 10);
      check("t5_uld", 64'(uld_pulses - base), 64'd1);
      check("t5_count", 64'(fifo_count), 64'd1);
      check("t5_data", pkt_data, make_word(100));
      pop_one();

      // Clear asserted in the PUSH cycle: packet lands, counters read zero.
      rx_data = make_word(7); rx_empty = 1'b0;
      wait_uld();
      @(negedge clk); rx_empty = 1'b1;
      @(negedge clk);
      @(negedge clk); clear_counters = 1'b1;
      @(negedge clk); clear_counters = 1'b0;
      repeat (3) @(negedge clk);
      check("clr_cnts", {good_cnt, parity_err_cnt, invalid_cnt, overflow_cnt}, 64'd0);
      check("clr_count", 64'(fifo_count), 64'd1);
      pop_one();

      // Leave a bad-parity packet queued so reset has something to flush.
      send_word(64'h0000_0000_0000_0006, 2);
      check("pre_rst_perr", 64'(parity_err_cnt), 64'd1);
      check("pre_rst_count", 64'(fifo_count), 64'd1);
      rx_data = make_word(9); rx_empty = 1'b0;
      wait_uld();
      @(negedge clk); reset_n = 1'b0; rx_empty = 1'b1;
      @(negedge clk); reset_n = 1'b1;
      repeat (6) @(negedge clk);
      check("t6_valid", 64'(pkt_valid), 64'd0);
      check("t6_count", 64'(fifo_count), 64'd0);
      check("t6_cnts", {good_cnt, parity_err_cnt, invalid_cnt, overflow_cnt}, 64'd0);
      send_word(make_word(11), 2);
      check("t6_after_good", 64'(good_cnt), 64'd1);
      check("t6_after_data", pkt_data, make_word(11));
      check("t6_after_type", 64'(pkt_type), 64'd1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
